// File: rtl/mem_subword_unit.sv
// mem_subword_unit: load/store sub-word unit between the datapath and a 32-bit
// data memory with a req/ack handshake.
// - Stores: narrows data to byte/half lanes, replicates it and drives byte enables.
// - Loads: picks the addressed lane and sign- or zero-extends it into RData_OUT.
// - Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses skip memory
//   and complete at once with Misalign_OUT=1. Without it, the offending low
//   address bits are ignored.
module mem_subword_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32   // four byte lanes; no other width is supported
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Req_IN,
    input  logic                  WE_IN,
    input  logic [1:0]            Size_IN,
    input  logic                  Unsigned_IN,
    input  logic [ADDR_WIDTH-1:0] Addr_IN,
    input  logic [DATA_WIDTH-1:0] WData_IN,
    output logic                  Busy_OUT,
    output logic                  Done_OUT,
    output logic [DATA_WIDTH-1:0] RData_OUT,
    output logic                  Misalign_OUT,
    output logic                  MemReq_OUT,
    output logic                  MemWE_OUT,
    output logic [ADDR_WIDTH-1:0] MemAddr_OUT,
    output logic [3:0]            MemBE_OUT,
    output logic [DATA_WIDTH-1:0] MemWData_OUT,
    input  logic [DATA_WIDTH-1:0] MemRData_IN,
    input  logic                  MemAck_IN
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [1:0]              r_addr_lo;
    logic                    r_misalign;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [3:0]              r_mem_be;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;

    logic                    w_accept;
    logic                    w_misalign;
    logic [3:0]              w_be_req;
    logic [DATA_WIDTH-1:0]   w_wdata_req;
    logic [DATA_WIDTH-1:0]   w_lane;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_ext;

    assign w_accept = (r_state == ST_IDLE) && Req_IN;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((Size_IN == SZ_HALF) && Addr_IN[0]) ||
                        (Size_IN[1] && (Addr_IN[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_be_req    = 4'b1111;
        w_wdata_req = WData_IN;
        case (Size_IN)
            SZ_BYTE: begin
                w_be_req    = 4'b0001 << Addr_IN[1:0];
                w_wdata_req = {4{WData_IN[7:0]}};
            end
            SZ_HALF: begin
                w_be_req    = Addr_IN[1] ? 4'b1100 : 4'b0011;
                w_wdata_req = {2{WData_IN[15:0]}};
            end
            default: ;  // word and reserved size behave as a full word
        endcase
    end

    // Lane selection and extension of the returned memory word.
    assign w_lane = MemRData_IN >> {r_addr_lo, 3'b000};
    assign w_half = r_addr_lo[1] ? MemRData_IN[31:16] : MemRData_IN[15:0];

    always_comb begin
        w_load_ext = MemRData_IN;
        case (r_size)
            SZ_BYTE: w_load_ext = r_unsigned ? {24'h0, w_lane[7:0]}
                                             : {{24{w_lane[7]}}, w_lane[7:0]};
            SZ_HALF: w_load_ext = r_unsigned ? {16'h0, w_half}
                                             : {{16{w_half[15]}}, w_half};
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        Busy_OUT     = 1'b1;
        Done_OUT     = 1'b0;
        MemReq_OUT   = 1'b0;
        Misalign_OUT = 1'b0;
        case (r_state)
            ST_IDLE: begin
                Busy_OUT = 1'b0;
                if (Req_IN) w_state_nxt = w_misalign ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                MemReq_OUT = 1'b1;
                if (MemAck_IN) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                Done_OUT     = 1'b1;
                Misalign_OUT = r_misalign;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture on acceptance and load result capture on ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_misalign  <= 1'b0;
            r_rdata     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_size      <= Size_IN;
                r_unsigned  <= Unsigned_IN;
                r_addr_lo   <= Addr_IN[1:0];
                r_misalign  <= w_misalign;
                r_mem_we    <= WE_IN;
                r_mem_addr  <= {Addr_IN[ADDR_WIDTH-1:2], 2'b00};
                r_mem_be    <= w_be_req;
                r_mem_wdata <= w_wdata_req;
            end
            if ((r_state == ST_ACCESS) && MemAck_IN && !r_mem_we) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    assign RData_OUT    = r_rdata;
    assign MemWE_OUT    = r_mem_we;
    assign MemAddr_OUT  = r_mem_addr;
    assign MemBE_OUT    = r_mem_be;
    assign MemWData_OUT = r_mem_wdata;

endmodule

// File: tb/tb_mem_subword_unit.sv
// tb_mem_subword_unit: directed bench for mem_subword_unit. Expected load
// results are queued when a request is driven and compared on each Done pulse.
module tb_mem_subword_unit;

    logic        clk;
    logic        rst_n;
    logic        Req_IN;
    logic        WE_IN;
    logic [1:0]  Size_IN;
    logic        Unsigned_IN;
    logic [31:0] Addr_IN;
    logic [31:0] WData_IN;
    logic        Busy_OUT;
    logic        Done_OUT;
    logic [31:0] RData_OUT;
    logic        Misalign_OUT;
    logic        MemReq_OUT;
    logic        MemWE_OUT;
    logic [31:0] MemAddr_OUT;
    logic [3:0]  MemBE_OUT;
    logic [31:0] MemWData_OUT;
    logic [31:0] MemRData_IN;
    logic        MemAck_IN;

    typedef struct {
        logic [31:0] rdata;
        logic        misalign;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    logic [31:0] model_rdata = 32'h0;

    mem_subword_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Req_IN       (Req_IN),
        .WE_IN        (WE_IN),
        .Size_IN      (Size_IN),
        .Unsigned_IN  (Unsigned_IN),
        .Addr_IN      (Addr_IN),
        .WData_IN     (WData_IN),
        .Busy_OUT     (Busy_OUT),
        .Done_OUT     (Done_OUT),
        .RData_OUT    (RData_OUT),
        .Misalign_OUT (Misalign_OUT),
        .MemReq_OUT   (MemReq_OUT),
        .MemWE_OUT    (MemWE_OUT),
        .MemAddr_OUT  (MemAddr_OUT),
        .MemBE_OUT    (MemBE_OUT),
        .MemWData_OUT (MemWData_OUT),
        .MemRData_IN  (MemRData_IN),
        .MemAck_IN    (MemAck_IN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_trap(input logic [1:0] size, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'b01) return addr[0];
        if (size[1])       return addr[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b00) begin
            case (addr[1:0])
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (size == 2'b01) return addr[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'b00) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (size == 2'b01) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        if (size == 2'b00) begin
            case (addr[1:0])
                2'd0:    b = word[7:0];
                2'd1:    b = word[15:8];
                2'd2:    b = word[23:16];
                default: b = word[31:24];
            endcase
            return (uns || !b[7]) ? {24'h000000, b} : {24'hFFFFFF, b};
        end
        if (size == 2'b01) begin
            h = addr[1] ? word[31:16] : word[15:0];
            return (uns || !h[15]) ? {16'h0000, h} : {16'hFFFF, h};
        end
        return word;
    endfunction

    // Scoreboard: every Done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && Done_OUT) begin
            done_count++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(Done_OUT), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rdata", RData_OUT, e.rdata);
                check("sb_misalign", 32'(Misalign_OUT), 32'(e.misalign));
            end
        end
    end

    // One complete access: drives the request, plays the memory side with
    // ack_delay wait states and checks the bus on every cycle.
    task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mem_word, input int ack_delay, input logic poke_req);
        logic        trap;
        int          dc0;
        exp_t        e;
        trap = model_trap(size, addr);
        if (!we && !trap) model_rdata = model_load(size, uns, addr, mem_word);
        e.rdata    = model_rdata;
        e.misalign = trap;
        sb_q.push_back(e);
        dc0 = done_count;

        @(negedge clk);
        Req_IN      = 1'b1;
        WE_IN       = we;
        Size_IN     = size;
        Unsigned_IN = uns;
        Addr_IN     = addr;
        WData_IN    = wdata;
        @(negedge clk);
        Req_IN = 1'b0;
        if (trap) begin
            check({tag, "_trap_noreq"}, 32'(MemReq_OUT), 32'h0);
            check({tag, "_trap_done"}, 32'(Done_OUT), 32'h1);
        end else begin
            for (int i = 0; i <= ack_delay; i++) begin
                if (i > 0) @(negedge clk);
                check({tag, "_memreq"}, 32'(MemReq_OUT), 32'h1);
                check({tag, "_busy"}, 32'(Busy_OUT), 32'h1);
                check({tag, "_no_early_done"}, 32'(Done_OUT), 32'h0);
                check({tag, "_memaddr"}, MemAddr_OUT, addr & 32'hFFFF_FFFC);
                check({tag, "_membe"}, 32'(MemBE_OUT), 32'(model_be(size, addr)));
                check({tag, "_memwe"}, 32'(MemWE_OUT), 32'(we));
                if (we) check({tag, "_memwdata"}, MemWData_OUT, model_wdata(size, wdata));
                Req_IN      = (poke_req && i == 1);
                MemRData_IN = (i == ack_delay) ? mem_word : 32'hDEAD_BEEF;
                MemAck_IN   = (i == ack_delay);
            end
            @(negedge clk);
            MemAck_IN   = 1'b0;
            Req_IN      = 1'b0;
            MemRData_IN = 32'h0BAD_0BAD;
            check({tag, "_done"}, 32'(Done_OUT), 32'h1);
            check({tag, "_req_dropped"}, 32'(MemReq_OUT), 32'h0);
        end
        @(negedge clk);
        check({tag, "_idle_after"}, 32'(Busy_OUT), 32'h0);
        check({tag, "_single_done"}, 32'(done_count), 32'(dc0 + 1));
        check({tag, "_rdata_hold"}, RData_OUT, model_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        Req_IN      = 1'b0;
        WE_IN       = 1'b0;
        Size_IN     = 2'b00;
        Unsigned_IN = 1'b0;
        Addr_IN     = 32'h0;
        WData_IN    = 32'h0;
        MemRData_IN = 32'h0;
        MemAck_IN   = 1'b0;

        #12;
        check("rst_busy",     32'(Busy_OUT), 32'h0);
        check("rst_done",     32'(Done_OUT), 32'h0);
        check("rst_rdata",    RData_OUT, 32'h0);
        check("rst_misalign", 32'(Misalign_OUT), 32'h0);
        check("rst_memreq",   32'(MemReq_OUT), 32'h0);
        check("rst_memwe",    32'(MemWE_OUT), 32'h0);
        check("rst_memaddr",  MemAddr_OUT, 32'h0);
        check("rst_membe",    32'(MemBE_OUT), 32'h0);
        check("rst_memwdata", MemWData_OUT, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_access("lb",   1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_80FF, 0, 1'b0);
        run_access("lbu",  1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 32'h1234_80FF, 0, 1'b0);
        run_access("lh",   1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0, 1'b0);
        run_access("lhu",  1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0, 1'b0);
        run_access("sb",   1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, 1'b0);
        run_access("lw_wait", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 3, 1'b1);
        run_access("lw_mis",  1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'h8765_4321, 0, 1'b0);
        run_access("lh_mis",  1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0, 32'h1111_F00F, 1, 1'b0);
        run_access("sh",   1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_5678, 32'h0, 1, 1'b0);
        run_access("lb_pos", 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h7F00_0000, 0, 1'b0);
        run_access("lw_rsv", 1'b0, 2'b11, 1'b0, 32'h0000_0404, 32'h0, 32'h0102_0304, 2, 1'b0);

        // Asynchronous reset in the middle of a waited access.
        @(negedge clk);
        Req_IN  = 1'b1;
        WE_IN   = 1'b0;
        Size_IN = 2'b10;
        Addr_IN = 32'h0000_0500;
        @(negedge clk);
        Req_IN = 1'b0;
        check("arst_pre_memreq", 32'(MemReq_OUT), 32'h1);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        model_rdata = 32'h0;
        #1;
        check("arst_memreq_drop", 32'(MemReq_OUT), 32'h0);
        check("arst_busy_drop",   32'(Busy_OUT), 32'h0);
        check("arst_rdata",       RData_OUT, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            MemAck_IN = (i == 0);
            check("arst_no_done", 32'(Done_OUT), 32'h0);
        end
        MemAck_IN = 1'b0;
        @(negedge clk);
        check("arst_no_done_late", 32'(Done_OUT), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", 32'(Busy_OUT), 32'h0);

        run_access("sw_after_rst", 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 1, 1'b0);
        run_access("lhu_after_rst", 1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0, 32'h8000_7FFF, 0, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
